// File: rtl/md_unit_if.sv
// Request/result bundle between decode/hazard logic and the multiply/divide unit.
interface md_unit_if #(
    parameter int width = 32
);
    logic             start;
    logic [2:0]       op;
    logic [width-1:0] D1;
    logic [width-1:0] D2;
    logic             busy;
    logic [width-1:0] HI;
    logic [width-1:0] LO;

    modport master (output start, op, D1, D2, input busy, HI, LO);
    modport slave  (input start, op, D1, D2, output busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit holding HI/LO. Results are computed on the accept
// edge and committed when a down-counter expires, modelling the iterative latency.
module md_unit #(
    parameter int width       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave bus
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0]       MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0]       DIV_N  = 4'(DIV_CYCLES);
    localparam logic [width-1:0] ZERO_W = {width{1'b0}};
    localparam logic [width-1:0] ONE_W  = {{(width-1){1'b0}}, 1'b1};

    logic [2*width-1:0] mul_a_s;
    logic [2*width-1:0] mul_b_s;
    logic [2*width-1:0] prod_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [width-1:0]   a_mag_s;
    logic [width-1:0]   b_mag_s;
    logic [width-1:0]   b_safe_s;
    logic [width-1:0]   q_mag_s;
    logic [width-1:0]   r_mag_s;
    logic [width-1:0]   quot_s;
    logic [width-1:0]   rem_s;
    logic               div_zero_s;

    logic               busy_r;
    logic [3:0]         cnt_r;
    logic [width-1:0]   hi_r;
    logic [width-1:0]   lo_r;
    logic [width-1:0]   pend_hi_r;
    logic [width-1:0]   pend_lo_r;
    logic               pend_wr_r;

    // Full-width product and sign-magnitude division of the current operands.
    always_comb begin
        if (bus.op == OP_MULT) begin
            mul_a_s = {{width{bus.D1[width-1]}}, bus.D1};
            mul_b_s = {{width{bus.D2[width-1]}}, bus.D2};
        end else begin
            mul_a_s = {ZERO_W, bus.D1};
            mul_b_s = {ZERO_W, bus.D2};
        end
        prod_s = mul_a_s * mul_b_s;

        a_neg_s = (bus.op == OP_DIV) & bus.D1[width-1];
        b_neg_s = (bus.op == OP_DIV) & bus.D2[width-1];
        if (a_neg_s) begin
            a_mag_s = ZERO_W - bus.D1;
        end else begin
            a_mag_s = bus.D1;
        end
        if (b_neg_s) begin
            b_mag_s = ZERO_W - bus.D2;
        end else begin
            b_mag_s = bus.D2;
        end

        // A zero divisor never commits, so any safe stand-in keeps the divider defined.
        div_zero_s = (bus.D2 == ZERO_W);
        if (div_zero_s) begin
            b_safe_s = ONE_W;
        end else begin
            b_safe_s = b_mag_s;
        end
        q_mag_s = a_mag_s / b_safe_s;
        r_mag_s = a_mag_s % b_safe_s;

        if (a_neg_s ^ b_neg_s) begin
            quot_s = ZERO_W - q_mag_s;
        end else begin
            quot_s = q_mag_s;
        end
        if (a_neg_s) begin
            rem_s = ZERO_W - r_mag_s;
        end else begin
            rem_s = r_mag_s;
        end
    end

    // Accept requests when idle, count down the busy window, commit HI/LO on expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r    <= 1'b0;
            cnt_r     <= 4'd0;
            hi_r      <= ZERO_W;
            lo_r      <= ZERO_W;
            pend_hi_r <= ZERO_W;
            pend_lo_r <= ZERO_W;
            pend_wr_r <= 1'b0;
        end else if (busy_r) begin
            cnt_r <= cnt_r - 4'd1;
            if (cnt_r == 4'd1) begin
                busy_r <= 1'b0;
                if (pend_wr_r) begin
                    hi_r <= pend_hi_r;
                    lo_r <= pend_lo_r;
                end
            end
        end else if (bus.start) begin
            case (bus.op)
                OP_MULT, OP_MULTU: begin
                    pend_hi_r <= prod_s[2*width-1:width];
                    pend_lo_r <= prod_s[width-1:0];
                    pend_wr_r <= 1'b1;
                    cnt_r     <= MULT_N;
                    busy_r    <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    pend_hi_r <= rem_s;
                    pend_lo_r <= quot_s;
                    pend_wr_r <= ~div_zero_s;
                    cnt_r     <= DIV_N;
                    busy_r    <= 1'b1;
                end
                OP_MTHI: hi_r <= bus.D1;
                OP_MTLO: lo_r <= bus.D1;
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.HI   = hi_r;
    assign bus.LO   = lo_r;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, multi-cycle corner
// sequences, then random operations against an arithmetic reference model.
module tb_md_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    md_unit_if #(.width(32)) bus ();
    md_unit #(.width(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2);
        bus.start = 1'b1;
        bus.op    = op;
        bus.D1    = d1;
        bus.D2    = d2;
    endtask

    // Count negedges with busy high; operands are scrambled to show they are not resampled.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 40) begin
            cycles++;
            bus.D1 = $urandom;
            bus.D2 = $urandom;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] ehi,
                          input logic [31:0] elo, input int ecyc);
        int c;
        drive(op, d1, d2);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(c);
        chk({name, " busy_len"}, 64'(c), 64'(ecyc));
        chk({name, " HI"}, {32'h0, bus.HI}, {32'h0, ehi});
        chk({name, " LO"}, {32'h0, bus.LO}, {32'h0, elo});
    endtask

    // Reference: architectural result from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cyc);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        cyc = 0;
        case (op)
            3'd0: begin up = 64'(sa * sb); m_hi = up[63:32]; m_lo = up[31:0]; cyc = 5; end
            3'd1: begin up = ua * ub;      m_hi = up[63:32]; m_lo = up[31:0]; cyc = 5; end
            3'd2: begin
                cyc = 10;
                if (b != 32'h0) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    up = 64'(sq); m_lo = up[31:0];
                    up = 64'(sr); m_hi = up[31:0];
                end
            end
            3'd3: begin
                cyc = 10;
                if (b != 32'h0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int c, c2, rc;
        logic [2:0]  rop;
        logic [31:0] rd1, rd2;

        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.D1    = 32'h0;
        bus.D2    = 32'h0;

        vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFD, 5};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000003, 32'h00000002, 32'hFFFFFFFD, 5};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{3'd4, 32'h11111111, 32'h00000000, 32'h11111111, 32'h80000000, 0};
        vecs[6]  = '{3'd5, 32'h22222222, 32'h00000000, 32'h11111111, 32'h22222222, 0};
        vecs[7]  = '{3'd2, 32'h00000005, 32'h00000000, 32'h11111111, 32'h22222222, 10};
        vecs[8]  = '{3'd3, 32'h00000005, 32'h00000000, 32'h11111111, 32'h22222222, 10};
        vecs[9]  = '{3'd6, 32'h33333333, 32'h44444444, 32'h11111111, 32'h22222222, 0};
        vecs[10] = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
        vecs[11] = '{3'd4, 32'hA5A5A5A5, 32'h00000000, 32'hA5A5A5A5, 32'h00000001, 0};
        vecs[12] = '{3'd5, 32'h5A5A5A5A, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A, 0};

        @(negedge clk);
        chk("reset busy", {63'h0, bus.busy}, 64'h0);
        chk("reset HI", {32'h0, bus.HI}, 64'h0);
        chk("reset LO", {32'h0, bus.LO}, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].d1, vecs[i].d2,
                   vecs[i].hi, vecs[i].lo, vecs[i].cyc);
        end
        m_hi = 32'hA5A5A5A5;
        m_lo = 32'h5A5A5A5A;

        // Asynchronous reset in the middle of a DIV, with the counter at 4.
        drive(3'd2, 32'd100, 32'd7);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        chk("middiv busy", {63'h0, bus.busy}, 64'h1);
        #1 reset = 1'b1;
        #1;
        chk("async busy", {63'h0, bus.busy}, 64'h0);
        chk("async HI", {32'h0, bus.HI}, 64'h0);
        chk("async LO", {32'h0, bus.LO}, 64'h0);
        #1 reset = 1'b0;
        @(negedge clk);
        repeat (15) @(negedge clk);
        chk("postrst busy", {63'h0, bus.busy}, 64'h0);
        chk("postrst HI", {32'h0, bus.HI}, 64'h0);
        chk("postrst LO", {32'h0, bus.LO}, 64'h0);
        m_hi = 32'h0;
        m_lo = 32'h0;

        // Requests issued while busy must be dropped.
        drive(3'd0, 32'h00010000, 32'h00010000);
        @(negedge clk);
        c = 0;
        if (bus.busy) c++;
        drive(3'd4, 32'hDEADBEEF, 32'h0);
        @(negedge clk);
        if (bus.busy) c++;
        drive(3'd0, 32'h00000003, 32'h00000003);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(c2);
        chk("ignore busy_len", 64'(c + c2), 64'd5);
        chk("ignore HI", {32'h0, bus.HI}, 64'h1);
        chk("ignore LO", {32'h0, bus.LO}, 64'h0);

        // Start held through a MULT: the commit edge is not an accept edge.
        drive(3'd0, 32'h00000002, 32'h00000003);
        @(negedge clk);
        drive(3'd5, 32'h00000077, 32'h0);
        c = 1;
        while (bus.busy === 1'b1 && c < 40) begin
            @(negedge clk);
            if (bus.busy === 1'b1) c++;
        end
        chk("hold busy_len", 64'(c), 64'd5);
        chk("hold commit LO", {32'h0, bus.LO}, 64'h6);
        chk("hold commit HI", {32'h0, bus.HI}, 64'h0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("hold accept LO", {32'h0, bus.LO}, 64'h77);
        chk("hold accept busy", {63'h0, bus.busy}, 64'h0);
        m_hi = 32'h0;
        m_lo = 32'h77;

        // Random back-to-back operations against the reference model.
        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            rd1 = $urandom;
            rd2 = $urandom;
            case ($urandom_range(0, 7))
                0: rd2 = 32'h0;
                1: begin rd1 = 32'h80000000; rd2 = 32'hFFFFFFFF; end
                2: rd2 = 32'($urandom_range(1, 9));
                default: ;
            endcase
            model(rop, rd1, rd2, rc);
            run_op($sformatf("rnd%0d op%0d", k, rop), rop, rd1, rd2, m_hi, m_lo, rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit for the CPU's EX stage; holds HI and LO.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from decode and models the multi-cycle latency with a busy flag; the hazard unit stalls on that flag.
- HI and LO are continuously driven into the downstream write-back data selector, which picks them for MFHI/MFLO.

Parameters:
- width, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy duration for MULT/MULTU (range 1-15).
- DIV_CYCLES, 10, busy duration for DIV/DIVU (range 1-15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; qualifies op.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved (no effect).
- D1  input  width  rs operand (dividend/multiplicand; MTHI/MTLO source).
- D2  input  width  rt operand (divisor/multiplier).
- busy  output  1  operation in progress.
- HI  output  width  HI register.
- LO  output  width  LO register.

Behaviour:
- Reset (asynchronous, any time): busy=0, HI=0, LO=0, counter=0, pending result discarded.
- Accept condition: start=1 and busy=0 at a rising edge. When busy=1, start is ignored entirely, including MTHI/MTLO; the stall logic must not issue requests then.
- MTHI/MTLO: HI (or LO) <= D1 on the accepting edge; new value is visible the next cycle; busy stays 0.
- MULT/MULTU/DIV/DIVU on the accepting edge:
  - Compute the full result from D1/D2 and latch it into internal pending registers.
  - Load the counter with N (MULT_CYCLES or DIV_CYCLES); busy=1.
- Each subsequent edge decrements the counter. On the edge where the counter goes 1->0:
  - HI/LO <= pending result;
  - busy <= 0.
- Timing: busy is high for exactly N cycles. The result is visible in the same cycle busy is first low again. HI/LO keep their old values throughout the busy window.
- MULT: signed 32x32 -> 64; HI=[63:32], LO=[31:0]. MULTU: unsigned.
- DIV: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 (no trap).
- DIVU: unsigned quotient/remainder.
- Divide by zero (D2=0, DIV or DIVU): busy still asserts for DIV_CYCLES; on completion HI and LO retain their pre-operation values.
- Back-to-back: start may be accepted in the first cycle busy=0, i.e. the same edge the previous result is written is not an accept edge. The next op is accepted one edge later.
- Reserved op with start=1: no state change; busy stays 0.
- Operands are sampled only on the accepting edge; D1/D2 changes during busy have no effect.

Test Plan:
- Reset: assert reset mid-DIV (counter=4) -> busy, HI and LO drop to 0 immediately, without waiting for clk; after release, no late write occurs.
- MULT D1=0xFFFFFFFF (-1), D2=0x00000003 -> busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFD. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFD.
- DIV D1=0xFFFFFFF9 (-7), D2=2 -> busy for 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU D1=7, D2=2 -> LO=3, HI=1.
- Divide by zero: preload HI=0x11111111 and LO=0x22222222 via MTHI/MTLO, then DIV with D2=0 -> busy for 10 cycles; HI and LO remain unchanged. Also check DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Ignored requests while busy: during a MULT, pulse MTHI D1=0xDEADBEEF and a second MULT -> both are ignored; final HI/LO equal the first MULT's result; busy length is unchanged.
- MTHI D1=0xA5A5A5A5, next cycle MTLO D1=0x5A5A5A5A -> busy stays 0; HI updates after the first edge and LO after the second. op=6 with start=1 -> no change.
